// File: rtl/gated_reg_bank_pkg.sv
// Shared mode encoding for the gated register bank and its channel slices.
package gated_reg_bank_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD   = 3'd0,
    MODE_LOAD   = 3'd1,
    MODE_CLEAR  = 3'd2,
    MODE_SET    = 3'd3,
    MODE_SHL    = 3'd4,
    MODE_SHR    = 3'd5,
    MODE_ROTL   = 3'd6,
    MODE_INVERT = 3'd7
  } reg_mode_e;

endpackage

// File: rtl/gated_reg_channel.sv
// One WIDTH-bit register slice: mode decode, serial-out bit, change pulse and write-lock.
module gated_reg_channel
  import gated_reg_bank_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [WIDTH-1:0]  i_d,
  input  logic              i_ser_in,
  input  logic              i_lock_set,
  input  logic              i_lock_clr,
  output logic [WIDTH-1:0]  o_q,
  output logic              o_ser_out,
  output logic              o_changed,
  output logic              o_locked
);

  logic [WIDTH-1:0] r_q;
  logic             r_ser_out;
  logic             r_changed;
  logic             r_locked;

  logic             w_act;
  logic [WIDTH-1:0] w_q_next;
  logic             w_ser_next;

  // Lock gates the operation using its value before this edge.
  assign w_act = i_en & ~r_locked;

  always_comb begin
    w_q_next   = r_q;
    w_ser_next = r_ser_out;
    if (w_act) begin
      unique case (reg_mode_e'(i_mode))
        MODE_HOLD:   w_q_next = r_q;
        MODE_LOAD:   w_q_next = i_d;
        MODE_CLEAR:  w_q_next = '0;
        MODE_SET:    w_q_next = '1;
        MODE_SHL: begin
          w_q_next   = {r_q[WIDTH-2:0], i_ser_in};
          w_ser_next = r_q[WIDTH-1];
        end
        MODE_SHR: begin
          w_q_next   = {i_ser_in, r_q[WIDTH-1:1]};
          w_ser_next = r_q[0];
        end
        MODE_ROTL: begin
          w_q_next   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_ser_next = r_q[WIDTH-1];
        end
        MODE_INVERT: w_q_next = ~r_q;
        default:     w_q_next = r_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q       <= RESET_VAL;
      r_ser_out <= 1'b0;
      r_changed <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_q       <= w_q_next;
      r_ser_out <= w_ser_next;
      r_changed <= (w_q_next != r_q);
      if (i_lock_set)      r_locked <= 1'b1;
      else if (i_lock_clr) r_locked <= 1'b0;
    end
  end

  assign o_q       = r_q;
  assign o_ser_out = r_ser_out;
  assign o_changed = r_changed;
  assign o_locked  = r_locked;

endmodule

// File: rtl/gated_reg_bank.sv
// Multi-channel clocked register bank; packs CHANNELS slices onto flat buses.
module gated_reg_bank
  import gated_reg_bank_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      CHANNELS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [MODE_W-1:0]         mode,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic                      ser_in,
  input  logic [CHANNELS-1:0]       lock_set,
  input  logic [CHANNELS-1:0]       lock_clr,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*WIDTH-1:0] q_bar,
  output logic [CHANNELS-1:0]       ser_out,
  output logic [CHANNELS-1:0]       changed,
  output logic [CHANNELS-1:0]       locked
);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    gated_reg_channel #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (en[gi]),
      .i_mode     (mode),
      .i_d        (d[gi*WIDTH +: WIDTH]),
      .i_ser_in   (ser_in),
      .i_lock_set (lock_set[gi]),
      .i_lock_clr (lock_clr[gi]),
      .o_q        (q[gi*WIDTH +: WIDTH]),
      .o_ser_out  (ser_out[gi]),
      .o_changed  (changed[gi]),
      .o_locked   (locked[gi])
    );
  end

  assign q_bar = ~q;

endmodule
